pipeline_stall_controller: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Combines load-use hazard detection,

---
 rtl/pipeline_stall_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Stall/flush sequencer for a 5-stage pipeline. One prioritised FSM
// (RUN, MEM_WAIT, HALTED, STEP) arbitrates between:
//   - multi-cycle data-memory waits (whole pipe frozen),
//   - taken-branch flushes of IF/ID and ID/EX,
//   - load-use hazards (PC and IF/ID held, one bubble into ID/EX),
//   - debug halt and single-step.
//
// The control outputs are combinational from the state and the current inputs,
// so they take effect in the same cycle. o_halted, o_mem_timeout and
// o_stall_count are registered.
//
// Ports
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_ID_EX_MemRead/rd    load in EX and its destination register
//   i_IF_ID_rs1/rs2       source registers of the instruction in ID
//   i_branch_taken        EX resolved a taken branch this cycle
//   i_dmem_req/ack        data-memory request and completion
//   i_halt_req            debug halt request (level)
//   i_step_req            debug single-step request (pulse)
//   o_PC_write            PC enable
//   o_IF_ID_write         IF/ID enable
//   o_mux_control         inject bubble into ID/EX
//   o_IF_ID_flush         clear IF/ID
//   o_ID_EX_flush         clear ID/EX
//   o_pipe_enable         EX/MEM and MEM/WB enable
//   o_halted              debug session active (HALTED, STEP, or a step's mem wait)
//   o_mem_timeout         sticky memory-wait timeout fault
//   o_stall_count         saturating count of cycles with o_PC_write=0
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] i_ID_EX_rd,
    input  logic [REG_ADDR_W-1:0] i_IF_ID_rs1,
    input  logic [REG_ADDR_W-1:0] i_IF_ID_rs2,
    input  logic                  i_branch_taken,
    input  logic                  i_dmem_req,
    input  logic                  i_dmem_ack,
    input  logic                  i_halt_req,
    input  logic                  i_step_req,
    output logic                  o_PC_write,
    output logic                  o_IF_ID_write,
    output logic                  o_mux_control,
    output logic                  o_IF_ID_flush,
    output logic                  o_ID_EX_flush,
    output logic                  o_pipe_enable,
    output logic                  o_halted,
    output logic                  o_mem_timeout,
    output logic [CNT_W-1:0]      o_stall_count
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STALL_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_STEP     = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              ret_halt_reg, ret_halt_next;
    logic              halted_reg;
    logic              mem_timeout_reg;
    logic [CNT_W-1:0]  stall_count_reg;

    logic load_use;
    logic mem_stall;
    logic apply_adv;     // this cycle follows the advance rules (branch/load-use/normal)
    logic timeout_set;
    logic adv_pc, adv_ifid, adv_mux, adv_flush;

    assign load_use  = i_ID_EX_MemRead && (i_ID_EX_rd != '0) &&
                       ((i_ID_EX_rd == i_IF_ID_rs1) || (i_ID_EX_rd == i_IF_ID_rs2));
    assign mem_stall = i_dmem_req && !i_dmem_ack;

    // Advance rules once a memory stall has been excluded. A taken branch
    // outranks load-use: the dependent instruction is on the wrong path and
    // gets flushed anyway, so no bubble is needed.
    always_comb begin
        adv_pc    = 1'b1;
        adv_ifid  = 1'b1;
        adv_mux   = 1'b0;
        adv_flush = 1'b0;
        if (i_branch_taken) begin
            adv_flush = 1'b1;
        end else if (load_use) begin
            adv_pc   = 1'b0;
            adv_ifid = 1'b0;
            adv_mux  = 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        ret_halt_next = ret_halt_reg;
        timeout_set   = 1'b0;
        apply_adv     = 1'b0;
        case (state_reg)
            ST_RUN, ST_STEP: begin
                if (mem_stall) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = '0;
                    // A step interrupted by memory must land back in HALTED.
                    ret_halt_next = (state_reg == ST_STEP);
                end else begin
                    apply_adv = 1'b1;
                    if ((state_reg == ST_STEP) || i_halt_req) begin
                        state_next = ST_HALTED;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Halt/step requests are deliberately not looked at here.
                if (i_dmem_ack) begin
                    apply_adv     = 1'b1;
                    state_next    = ret_halt_reg ? ST_HALTED : ST_RUN;
                    wait_cnt_next = '0;
                    ret_halt_next = 1'b0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    timeout_set   = 1'b1;
                    state_next    = ST_HALTED;
                    wait_cnt_next = '0;
                    ret_halt_next = 1'b0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_HALTED: begin
                if (i_step_req) begin
                    state_next = ST_STEP;
                end else if (!i_halt_req) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign o_PC_write    = !i_reset && apply_adv && adv_pc;
    assign o_IF_ID_write = !i_reset && apply_adv && adv_ifid;
    assign o_mux_control = !i_reset && apply_adv && adv_mux;
    assign o_IF_ID_flush = !i_reset && apply_adv && adv_flush;
    assign o_ID_EX_flush = !i_reset && apply_adv && adv_flush;
    assign o_pipe_enable = !i_reset && apply_adv;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= ST_RUN;
            wait_cnt_reg    <= '0;
            ret_halt_reg    <= 1'b0;
            halted_reg      <= 1'b0;
            mem_timeout_reg <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            ret_halt_reg <= ret_halt_next;
            // The debug session stays visible through a step and through
            // the memory wait of a step.
            halted_reg   <= (state_next == ST_HALTED) || (state_next == ST_STEP) ||
                            ((state_next == ST_MEM_WAIT) && ret_halt_next);
            if (timeout_set) begin
                mem_timeout_reg <= 1'b1;
            end
            if (!o_PC_write && (stall_count_reg != STALL_MAX)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
        end
    end

    assign o_halted      = halted_reg;
    assign o_mem_timeout = mem_timeout_reg;
    assign o_stall_count = stall_count_reg;

endmodule
